// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, SYNC_STAGES operand stages and a single-entry output register.
// Optional macro ALU_FLAGS_EN adds a registered {C, V, N, Z} flags output.
module alu_pipe #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Sel,
  input  logic             CarryIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int LAST = SYNC_STAGES - 1;

  logic [WIDTH-1:0] a_q   [SYNC_STAGES];
  logic [WIDTH-1:0] a_d   [SYNC_STAGES];
  logic [WIDTH-1:0] b_q   [SYNC_STAGES];
  logic [WIDTH-1:0] b_d   [SYNC_STAGES];
  logic [4:0]       sel_q [SYNC_STAGES];
  logic [4:0]       sel_d [SYNC_STAGES];
  logic             ci_q  [SYNC_STAGES];
  logic             ci_d  [SYNC_STAGES];
  logic             vld_q [SYNC_STAGES];
  logic             vld_d [SYNC_STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_y;
  logic             stall;

  function automatic logic [WIDTH-1:0] calc_y(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [4:0]       sel,
                                               input logic             ci);
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] y;
    sum = '0;
    y   = '0;
    case (sel[4:3])
      2'b00: begin
        if (sel[2]) begin
          case (sel[1:0])
            2'b00: y = a;
            2'b01: begin
              sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
              y   = sum[WIDTH-1:0];
            end
            2'b10: begin
              sum = {1'b0, a} + {1'b0, b};
              y   = sum[WIDTH-1:0];
            end
            default: y = b;
          endcase
        end else begin
          case (sel[1:0])
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~a;
          endcase
        end
      end
      2'b01:   y = {a[WIDTH-2:0], 1'b0};
      2'b10:   y = {1'b0, a[WIDTH-1:1]};
      default: y = '0;
    endcase
    return y;
  endfunction

`ifdef ALU_FLAGS_EN
  // Returns {C, V}; only adds and shifts produce a carry, only adds overflow.
  function automatic logic [1:0] calc_cv(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [4:0]       sel,
                                         input logic             ci);
    logic [WIDTH:0] sum;
    logic c;
    logic v;
    sum = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (sel[4:3])
      2'b00: begin
        if (sel[2] && (sel[1:0] == 2'b01 || sel[1:0] == 2'b10)) begin
          sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (sel[1:0] == 2'b01) & ci};
          c   = sum[WIDTH];
          v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
      end
      2'b01:   c = a[WIDTH-1];
      2'b10:   c = a[0];
      default: c = 1'b0;
    endcase
    return {c, v};
  endfunction

  logic [3:0] flags_q, flags_d;
  logic [1:0] res_cv;
`endif

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign res_y     = calc_y(a_q[LAST], b_q[LAST], sel_q[LAST], ci_q[LAST]);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sel_d = sel_q;
    ci_d  = ci_q;
    vld_d = vld_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      a_d[0]   = A;
      b_d[0]   = B;
      sel_d[0] = Sel;
      ci_d[0]  = CarryIn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        sel_d[k] = sel_q[k-1];
        ci_d[k]  = ci_q[k-1];
      end
    end
  end

  // Compute stage -> output register; a bubble only clears out_valid, Y keeps its value.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (!stall) begin
      out_valid_d = vld_q[LAST];
      if (vld_q[LAST]) y_d = res_y;
    end
  end

`ifdef ALU_FLAGS_EN
  assign res_cv = calc_cv(a_q[LAST], b_q[LAST], sel_q[LAST], ci_q[LAST]);
  assign flags  = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (!stall && vld_q[LAST])
      flags_d = {res_cv[1], res_cv[0], res_y[WIDTH-1], (res_y == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end
`endif

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sel_q <= sel_d;
    ci_q  <= ci_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) vld_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: default 8-bit/3-stage instance and a 16-bit/1-stage instance.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, ci8;
  logic [7:0] a8, b8, y8;
  logic [4:0] sel8;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, ci16;
  logic [15:0] a16, b16, y16;
  logic [4:0]  sel16;
`ifdef ALU_FLAGS_EN
  logic [3:0] flags8, flags16;
`endif

  int errors = 0;
  int checks = 0;

  alu_pipe u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .Sel(sel8), .CarryIn(ci8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Y(y8)
`ifdef ALU_FLAGS_EN
    , .flags(flags8)
`endif
  );

  alu_pipe #(.WIDTH(16), .SYNC_STAGES(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Sel(sel16), .CarryIn(ci16),
    .out_valid(out_valid16), .out_ready(out_ready16), .Y(y16)
`ifdef ALU_FLAGS_EN
    , .flags(flags16)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [4:0] sel, input logic ci);
    a8 = a; b8 = b; sel8 = sel; ci8 = ci; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  // Bounded wait for the next 8-bit result, then check it and let it be consumed.
  task automatic expect8(input string tag, input logic [7:0] ey, input logic [3:0] ef);
    for (int i = 0; i < 10 && !out_valid8; i++) tick();
    chk({tag, "_valid"}, 64'(out_valid8), 64'd1);
    chk({tag, "_y"}, 64'(y8), 64'(ey));
`ifdef ALU_FLAGS_EN
    chk({tag, "_flags"}, 64'(flags8), 64'(ef));
`else
    if (ef == 4'hF) $display("note: unexpected flag code");
`endif
    tick();
  endtask

  initial begin
    int sent, rcv, hold;
    bit seen, leaked;
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; sel8 = 0; ci8 = 0;
    in_valid16 = 0; out_ready16 = 1; a16 = 0; b16 = 0; sel16 = 0; ci16 = 0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid8), 64'd0);
    chk("rst_y", 64'(y8), 64'd0);
    chk("rst_in_ready", 64'(in_ready8), 64'd1);
    chk("rst_out_valid16", 64'(out_valid16), 64'd0);
    rst = 1'b0;

    // Test 1: exact latency of 4 edges and a single-cycle result.
    send8(8'h3C, 8'h05, 5'b00110, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_not_yet", 64'(out_valid8), 64'd0);
      tick();
    end
    chk("t1_valid_at_4", 64'(out_valid8), 64'd1);
    chk("t1_y", 64'(y8), 64'h41);
`ifdef ALU_FLAGS_EN
    chk("t1_flags", 64'(flags8), 64'h0);
`endif
    tick();
    chk("t1_one_cycle", 64'(out_valid8), 64'd0);

    // Test 2: add-with-carry carry out, then signed overflow.
    send8(8'hFF, 8'h01, 5'b00101, 1'b1);
    expect8("t2_adc", 8'h01, 4'b1000);
    send8(8'h7F, 8'h01, 5'b00110, 1'b0);
    expect8("t2_ovf", 8'h80, 4'b0110);

    // Test 3: six back-to-back ops with three stalled cycles on the first result.
    sent = 0; rcv = 0; hold = 0; seen = 0;
    a8 = 0; sel8 = 5'b00111; ci8 = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      in_valid8 = (sent < 6);
      b8 = 8'(sent + 1);
      if (out_valid8) seen = 1;
      out_ready8 = !(seen && hold < 3);
      #1;
      if (!out_ready8) begin
        chk("t3_stall_in_ready", 64'(in_ready8), 64'd0);
        chk("t3_stall_hold_y", 64'(y8), 64'h01);
        hold++;
      end
      if (out_valid8 && out_ready8) begin
        chk("t3_order", 64'(y8), 64'(rcv + 1));
        rcv++;
      end
      if (in_valid8 && in_ready8) sent++;
      tick();
    end
    in_valid8 = 0; out_ready8 = 1;
    chk("t3_count", 64'(rcv), 64'd6);
    chk("t3_stall_cycles", 64'(hold), 64'd3);
    leaked = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid8) leaked = 1;
      tick();
    end
    chk("t3_no_dup", 64'(leaked), 64'd0);

    // Test 4: shifts and the constant-zero opcode.
    send8(8'h81, 8'h00, 5'b10000, 1'b0);
    expect8("t4_shr", 8'h40, 4'b1000);
    send8(8'h81, 8'h00, 5'b01000, 1'b0);
    expect8("t4_shl", 8'h02, 4'b1000);
    send8(8'h81, 8'h00, 5'b11111, 1'b0);
    expect8("t4_zero", 8'h00, 4'b0001);

    // Test 5: asynchronous reset with ops in flight.
    send8(8'h33, 8'h00, 5'b00100, 1'b0);
    send8(8'h11, 8'h00, 5'b00100, 1'b0);
    send8(8'h22, 8'h00, 5'b00100, 1'b0);
    chk("t5_pre_valid", 64'(out_valid8), 64'd0);
    tick();
    chk("t5_pre_y", 64'(y8), 64'h33);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid8), 64'd0);
    chk("t5_async_y", 64'(y8), 64'd0);
`ifdef ALU_FLAGS_EN
    chk("t5_async_flags", 64'(flags8), 64'd0);
`endif
    tick();
    rst = 1'b0;
    leaked = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid8) leaked = 1;
      tick();
    end
    chk("t5_nothing_after", 64'(leaked), 64'd0);
    send8(8'h5A, 8'h00, 5'b00100, 1'b0);
    tick(); tick();
    chk("t5_lat_not_yet", 64'(out_valid8), 64'd0);
    tick();
    chk("t5_lat_valid", 64'(out_valid8), 64'd1);
    chk("t5_lat_y", 64'(y8), 64'h5A);
    tick();

    // Test 6: 16-bit, single operand stage.
    a16 = 16'hF0F0; b16 = 16'h0FF0; sel16 = 5'b00010; in_valid16 = 1;
    tick();
    in_valid16 = 0;
    chk("t6_not_yet", 64'(out_valid16), 64'd0);
    tick();
    chk("t6_xor_valid", 64'(out_valid16), 64'd1);
    chk("t6_xor_y", 64'(y16), 64'hFF00);
    a16 = 16'hFFFF; b16 = 16'h0001; sel16 = 5'b00110; in_valid16 = 1;
    tick();
    in_valid16 = 0;
    tick();
    chk("t6_add_valid", 64'(out_valid16), 64'd1);
    chk("t6_add_y", 64'(y16), 64'h0000);
`ifdef ALU_FLAGS_EN
    chk("t6_add_flags", 64'(flags16), 64'b1001);
`endif
    tick();
    chk("t6_drain", 64'(out_valid16), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 8-bit registered ALU. Operand width and the number of input register stages are configurable. A valid/ready handshake on both input and output allows backpressure, and a single-entry output register holds the result until it is taken. The block sits between the operand/opcode source (register file or sequencer) and the result consumer in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2 to 64.
SYNC_STAGES, 3, number of input register stages before the compute stage; legal range 1 to 4.

Ports:
clk  input  1  rising-edge clock for all state.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  A, B, Sel and CarryIn are valid this cycle.
in_ready  output  1  block accepts an operation this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
Sel  input  5  opcode; encoding given under Behaviour.
CarryIn  input  1  carry input; used by add-with-carry only.
out_valid  output  1  Y (and flags) hold a result.
out_ready  input  1  consumer takes the result this cycle.
Y  output  WIDTH  registered result.
flags  output  4  {C, V, N, Z}; present only with ALU_FLAGS_EN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst=1: all stage valid bits, out_valid, Y and flags are 0.
  - In-flight operations are discarded; nothing emerges after reset is released.
- Transfer: an operation is accepted on a rising edge with in_valid=1 and in_ready=1.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - While stalled, every stage and the output register hold their contents.
- Pipeline: SYNC_STAGES operand stages, then combinational compute, then the output register.
  - Latency: the accepting edge loads stage 1. With no stall, out_valid rises after edge SYNC_STAGES+1, counting the accepting edge as 1.
  - With SYNC_STAGES=3, a result appears 4 edges after acceptance.
- Bubbles: an edge with in_valid=0 and no stall loads a bubble (stage valid=0).
  - A bubble reaching the output register clears out_valid if the previous result was taken.
- Throughput: one operation per cycle. Order is preserved. No drop or duplicate under any out_ready pattern.
- Simultaneous output take and new result: when out_valid=1, out_ready=1 and the compute stage is valid on the same edge, Y is replaced with no gap cycle.
- Opcode Sel[4:3]=00, Sel[2]=1 (arithmetic):
  - Sel[1:0]=00: Y=A.
  - Sel[1:0]=01: Y=A+B+CarryIn.
  - Sel[1:0]=10: Y=A+B.
  - Sel[1:0]=11: Y=B.
- Opcode Sel[4:3]=00, Sel[2]=0 (logic):
  - Sel[1:0]=00: A&B.
  - Sel[1:0]=01: A|B.
  - Sel[1:0]=10: A^B.
  - Sel[1:0]=11: ~A.
- Opcode Sel[4:3]=01: Y=A<<1, zero fill. 10: Y=A>>1, logical, zero fill. 11: Y=0. Sel[2:0] is ignored for these.
- Width rule: sums are computed at WIDTH+1 bits; Y is the low WIDTH bits, so results wrap modulo 2^WIDTH.
- Every encoding is defined; Y never goes X after reset.

Optional Feature:
Macro: ALU_FLAGS_EN.
- Defined: flags are registered alongside Y and update only when Y updates.
  - Z = (Y==0).
  - N = Y[WIDTH-1].
  - C = sum bit WIDTH for add and add-with-carry; A[WIDTH-1] for shift left; A[0] for shift right; 0 otherwise.
  - V = signed overflow for add and add-with-carry (operands share a sign and the result sign differs); 0 otherwise.
  - Reset value 4'b0000.
- Not defined: the flags port and its registers are absent; all other behaviour is identical.

Test Plan:
1. Reset, then out_ready=1 and a single op A=8'h3C, B=8'h05, Sel=5'b00110 -> out_valid high exactly 4 edges after acceptance, Y=8'h41 for one cycle, Z=0, C=0.
2. A=8'hFF, B=8'h01, CarryIn=1, Sel=5'b00101 -> Y=8'h01, C=1, V=0; then A=8'h7F, B=8'h01, Sel=5'b00110 -> Y=8'h80, V=1, N=1.
3. Back-to-back ops (Y=8'h01, 8'h02, ..., 8'h06), out_ready held low for 3 cycles once the first result appears -> in_ready low for those cycles, Y holds 8'h01, all six results then appear in order, none lost or repeated.
4. A=8'h81, Sel=5'b10000 -> Y=8'h40, C=1; A=8'h81, Sel=5'b01000 -> Y=8'h02, C=1; Sel=5'b11111 -> Y=8'h00, Z=1.
5. Two ops in flight, rst pulsed mid-cycle (asynchronous) -> out_valid, Y and flags go 0 immediately, nothing emerges afterwards; the next accepted op completes with normal latency.
6. WIDTH=16, SYNC_STAGES=1: A=16'hF0F0, B=16'h0FF0, Sel=5'b00010 -> Y=16'hFF00 after 2 edges; A=16'hFFFF, B=16'h0001, Sel=5'b00110 -> Y=16'h0000, C=1, Z=1.
